md5_core_scheduler: RTL and testbench

//  Dispatches 128-bit candidate messages to NCORES pancham MD5 cores, tracks each core's in-flight message,

---
 rtl/md5_core_scheduler_pkg.sv | 24 ++
 rtl/md5_core_scheduler_rr_pick.sv | 34 +++
 rtl/md5_core_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_md5_core_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_core_scheduler_pkg.sv
// Shared definitions for the MD5 core scheduler: FSM state encodings, datapath widths
// and a small population-count helper used by the optional digest counter.
package md5_core_scheduler_pkg;

  localparam int MD5_W   = 128;
  localparam int WIDTH_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FOUND = 2'd3
  } sched_state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/md5_core_scheduler_rr_pick.sv
// md5_rr_pick: round-robin priority picker. Grants the first requester at or after ptr_i,
// wrapping at N; returns the grant one-hot, its index and whether anything was granted.
module md5_rr_pick #(
  parameter int N    = 2,
  parameter int IDXW = 3
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [IDXW-1:0] idx_o,
  output logic            any_o
);

  logic found;
  logic take;

  // Walk offsets from the pointer; the first requesting slot wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    take    = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        take       = !found && req_i[j] && (((int'(ptr_i) + i) % N) == j);
        grant_o[j] = grant_o[j] | take;
        idx_o      = take ? IDXW'(j) : idx_o;
        found      = found | take;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/md5_core_scheduler.sv
// md5_core_scheduler: dispatches candidates to NCORES MD5 cores, tracks in-flight messages and
// latches the first digest matching the target. Optional macro PERF_CNT_EN adds hash_count.
module md5_core_scheduler
  import md5_core_scheduler_pkg::*;
#(
  parameter int NCORES   = 2,
  parameter int MSG_BITS = 64,
  parameter int IDXW     = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        resume,
  input  logic [MD5_W-1:0]            target,
  input  logic [MD5_W-1:0]            cand_data,
  input  logic                        cand_valid,
  output logic                        cand_ready,
  output logic [NCORES*MD5_W-1:0]     core_msg,
  output logic [NCORES*WIDTH_W-1:0]   core_msg_width,
  output logic [NCORES-1:0]           core_msg_valid,
  input  logic [NCORES-1:0]           core_ready,
  input  logic [NCORES*MD5_W-1:0]     core_out,
  input  logic [NCORES-1:0]           core_out_valid,
  output logic [NCORES-1:0]           busy,
  output logic                        found,
  output logic [MD5_W-1:0]            found_msg,
  output logic [IDXW-1:0]             found_core
`ifdef PERF_CNT_EN
  ,
  output logic [47:0]                 hash_count
`endif
);

  sched_state_e                   state_q, state_d;
  logic [NCORES-1:0]              busy_q, busy_d;
  logic [NCORES-1:0]              valid_q, valid_d;
  logic [NCORES-1:0][MD5_W-1:0]   shadow_q, shadow_d;
  logic [IDXW-1:0]                rr_q, rr_d;
  logic                           found_q, found_d;
  logic [MD5_W-1:0]               found_msg_q, found_msg_d;
  logic [IDXW-1:0]                found_core_q, found_core_d;

  logic [NCORES-1:0]              eligible, grant, done, hit;
  logic [IDXW-1:0]                pick_idx, hit_idx;
  logic [MD5_W-1:0]               hit_msg;
  logic                           pick_any, accept, compare_en, hit_any;

  assign eligible   = core_ready & ~busy_q;
  assign cand_ready = (state_q == ST_RUN) && pick_any;
  assign accept     = cand_valid && cand_ready;
  assign compare_en = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done       = core_out_valid & busy_q;

  md5_rr_pick #(.N(NCORES), .IDXW(IDXW)) u_pick (
    .req_i   (eligible),
    .ptr_i   (rr_q),
    .grant_o (grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Compare finished digests; a descending scan leaves the lowest hitting index.
  always_comb begin
    hit     = '0;
    hit_idx = '0;
    hit_msg = '0;
    for (int k = 0; k < NCORES; k++) begin
      hit[k] = compare_en && done[k] && (core_out[k*MD5_W +: MD5_W] == target);
    end
    for (int k = NCORES - 1; k >= 0; k--) begin
      hit_idx = hit[k] ? IDXW'(k) : hit_idx;
      hit_msg = hit[k] ? shadow_q[k] : hit_msg;
    end
    hit_any = |hit;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RUN;
        else        state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (hit_any)      state_d = ST_FOUND;
        else if (!enable) state_d = ST_DRAIN;
        else              state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (hit_any)          state_d = ST_FOUND;
        else if (enable)      state_d = ST_RUN;
        else if (busy_q == '0) state_d = ST_IDLE;
        else                  state_d = ST_DRAIN;
      end
      ST_FOUND: begin
        if (resume) state_d = enable ? ST_RUN : ST_IDLE;
        else        state_d = ST_FOUND;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Dispatch, in-flight tracking and hit capture; completions clear busy in every state.
  always_comb begin
    busy_d       = busy_q & ~done;
    shadow_d     = shadow_q;
    valid_d      = '0;
    rr_d         = rr_q;
    found_d      = found_q;
    found_msg_d  = found_msg_q;
    found_core_d = found_core_q;
    if (accept) begin
      busy_d  = busy_d | grant;
      valid_d = grant;
      rr_d    = (pick_idx == IDXW'(NCORES - 1)) ? '0 : pick_idx + 1'b1;
      for (int k = 0; k < NCORES; k++) begin
        shadow_d[k] = grant[k] ? cand_data : shadow_q[k];
      end
    end else begin
      valid_d = '0;
    end
    if (hit_any) begin
      found_d      = 1'b1;
      found_msg_d  = hit_msg;
      found_core_d = hit_idx;
    end else if ((state_q == ST_FOUND) && resume) begin
      found_d = 1'b0;
    end else begin
      found_d = found_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      busy_q       <= '0;
      valid_q      <= '0;
      shadow_q     <= '0;
      rr_q         <= '0;
      found_q      <= 1'b0;
      found_msg_q  <= '0;
      found_core_q <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      shadow_q     <= shadow_d;
      rr_q         <= rr_d;
      found_q      <= found_d;
      found_msg_q  <= found_msg_d;
      found_core_q <= found_core_d;
    end
  end

  assign core_msg       = shadow_q;
  assign core_msg_valid = valid_q;
  assign core_msg_width = {NCORES{WIDTH_W'(MSG_BITS)}};
  assign busy           = busy_q;
  assign found          = found_q;
  assign found_msg      = found_msg_q;
  assign found_core     = found_core_q;

`ifdef PERF_CNT_EN
  logic [47:0] cnt_q, cnt_d;
  logic [48:0] cnt_sum;

  // Count every compared digest, saturating at all-ones.
  always_comb begin
    cnt_sum = {1'b0, cnt_q} + 49'(popcount8(8'(compare_en ? done : '0)));
    cnt_d   = cnt_sum[48] ? '1 : cnt_sum[47:0];
  end

  // Digest counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hash_count = cnt_q;
`endif

endmodule

// File: tb/tb_md5_core_scheduler.sv
// Self-checking bench for md5_core_scheduler with two behavioural cores of programmable latency.
module tb_md5_core_scheduler;

  localparam logic [127:0] MSG_A = {8'h61, 120'h0};
  localparam logic [127:0] MSG_B = {8'h62, 120'h0};
  localparam logic [127:0] MD5_A = 128'h0cc175b9c0f1b6a831c399e269772661;
  localparam logic [127:0] MD5_B = 128'h92eb5ffee6ae2fec3ad71c777531578f;
  localparam logic [127:0] NOHIT = {128{1'b1}};

  logic         clk, reset, enable, resume, cand_valid, cand_ready, found;
  logic [127:0] target, cand_data, found_msg;
  logic [255:0] core_msg, core_out;
  logic [15:0]  core_msg_width;
  logic [1:0]   core_msg_valid, core_ready, core_out_valid, busy;
  logic [2:0]   found_core;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]   m_busy, mdl_ov, inj_valid;
  int           m_cnt [2];
  int           lat [2];
  logic [127:0] m_msg [2];
  logic [127:0] mdl_out [2];
  logic [127:0] inj_out;
  bit           all_hit;

  md5_core_scheduler #(.NCORES(2), .MSG_BITS(64), .IDXW(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .resume         (resume),
    .target         (target),
    .cand_data      (cand_data),
    .cand_valid     (cand_valid),
    .cand_ready     (cand_ready),
    .core_msg       (core_msg),
    .core_msg_width (core_msg_width),
    .core_msg_valid (core_msg_valid),
    .core_ready     (core_ready),
    .core_out       (core_out),
    .core_out_valid (core_out_valid),
    .busy           (busy),
    .found          (found),
    .found_msg      (found_msg),
    .found_core     (found_core)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] mk(input logic [7:0] c);
    return {c, 120'h0};
  endfunction

  function automatic logic [127:0] model_digest(input logic [127:0] m);
    if (all_hit) return target;
    if (m == MSG_A) return MD5_A;
    if (m == MSG_B) return MD5_B;
    return ~m;
  endfunction

  function automatic logic [127:0] lane(input int k);
    return core_msg[k*128 +: 128];
  endfunction

  // Behavioural cores: fixed latency from msg_valid to a one-cycle out_valid pulse.
  assign core_ready     = ~m_busy;
  assign core_out_valid = mdl_ov | inj_valid;
  assign core_out       = {inj_valid[1] ? inj_out : mdl_out[1], inj_valid[0] ? inj_out : mdl_out[0]};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_busy[k]  <= 1'b0;
        m_cnt[k]   <= 0;
        mdl_ov[k]  <= 1'b0;
        mdl_out[k] <= '0;
        m_msg[k]   <= '0;
      end else begin
        mdl_ov[k] <= 1'b0;
        if (m_busy[k]) begin
          if (m_cnt[k] == 0) begin
            mdl_ov[k]  <= 1'b1;
            mdl_out[k] <= model_digest(m_msg[k]);
            m_busy[k]  <= 1'b0;
          end else begin
            m_cnt[k] <= m_cnt[k] - 1;
          end
        end else if (core_msg_valid[k]) begin
          m_busy[k] <= 1'b1;
          m_msg[k]  <= core_msg[k*128 +: 128];
          m_cnt[k]  <= lat[k] - 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic offer(input logic [127:0] m, input int budget, output bit ok);
    ok = 1'b0;
    cand_data  = m;
    cand_valid = 1'b1;
    for (int t = 0; t < budget && !ok; t++) begin
      #1;
      if (cand_ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    cand_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int t;
    t = 0;
    while (busy !== 2'b00 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(name, busy, 2'b00);
  endtask

  task automatic wait_found(input string name, input int budget);
    int t;
    t = 0;
    while (found !== 1'b1 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(name, found, 1'b1);
  endtask

  task automatic pulse_resume();
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cand_ready"}, cand_ready, 1'b0);
    chk({tag, "_busy"}, busy, 2'b00);
    chk({tag, "_valid"}, core_msg_valid, 2'b00);
    chk({tag, "_lane0"}, lane(0), '0);
    chk({tag, "_lane1"}, lane(1), '0);
    chk({tag, "_width"}, core_msg_width, 16'h4040);
    chk({tag, "_found"}, found, 1'b0);
    chk({tag, "_found_msg"}, found_msg, '0);
    chk({tag, "_found_core"}, found_core, 3'd0);
  endtask

  typedef struct {
    logic [127:0] cand;
    logic [127:0] tgt;
    logic [1:0]   exp_valid;
    int           exp_core;
    bit           exp_hit;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int pulses;
    bit rdy_seen;

    vecs[0] = '{mk(8'h70), MD5_A, 2'b10, 1, 1'b0};
    vecs[1] = '{MSG_A,     MD5_A, 2'b01, 0, 1'b1};
    vecs[2] = '{MSG_B,     MD5_A, 2'b10, 1, 1'b0};
    vecs[3] = '{MSG_B,     MD5_B, 2'b01, 0, 1'b1};
    vecs[4] = '{MSG_A,     MD5_B, 2'b10, 1, 1'b0};

    reset = 1'b1; enable = 1'b0; resume = 1'b0; target = NOHIT;
    cand_data = '0; cand_valid = 1'b0; inj_valid = 2'b00; inj_out = '0;
    all_hit = 1'b0; lat[0] = 20; lat[1] = 20;
    repeat (3) @(negedge clk);
    chk_reset_state("rst");

    // 1: two accepts fill both cores
    reset = 1'b0; enable = 1'b1;
    offer(MSG_A, 10, ok);
    chk("t1_acc_a", ok, 1'b1);
    chk("t1_valid_a", core_msg_valid, 2'b01);
    chk("t1_lane0", lane(0), MSG_A);
    offer(MSG_B, 10, ok);
    chk("t1_acc_b", ok, 1'b1);
    chk("t1_valid_b", core_msg_valid, 2'b10);
    chk("t1_lane1", lane(1), MSG_B);
    chk("t1_busy", busy, 2'b11);
    cand_data = mk(8'h63); cand_valid = 1'b1;
    #1 chk("t1_ready_full", cand_ready, 1'b0);
    cand_valid = 1'b0;
    wait_idle("t1_idle", 60);
    chk("t1_found", found, 1'b0);
    chk("t1_ready_free", cand_ready, 1'b1);

    // 2: hit on core 1
    target = MD5_B;
    offer(MSG_A, 10, ok);
    chk("t2_valid_a", core_msg_valid, 2'b01);
    offer(MSG_B, 10, ok);
    chk("t2_valid_b", core_msg_valid, 2'b10);
    wait_found("t2_found", 80);
    chk("t2_core", found_core, 3'd1);
    chk("t2_msg", found_msg, MSG_B);
    cand_data = mk(8'h78); cand_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("t2_ready", cand_ready, 1'b0);
    chk("t2_busy", busy, 2'b00);
    chk("t2_no_dispatch", core_msg_valid, 2'b00);
    cand_valid = 1'b0;

    // 5: resume with enable high continues from the pointer
    pulse_resume();
    chk("t5_found", found, 1'b0);
    chk("t5_msg_held", found_msg, MSG_B);
    chk("t5_core_held", found_core, 3'd1);
    offer(mk(8'h63), 10, ok);
    chk("t5_acc", ok, 1'b1);
    chk("t5_valid", core_msg_valid, 2'b01);
    wait_idle("t5_idle", 60);
    chk("t5_nohit", found, 1'b0);

    // 3: simultaneous hits, lowest index wins
    all_hit = 1'b1; lat[0] = 20; lat[1] = 21;
    offer(mk(8'h64), 10, ok);
    chk("t3_valid_d", core_msg_valid, 2'b10);
    offer(mk(8'h65), 10, ok);
    chk("t3_valid_e", core_msg_valid, 2'b01);
    wait_found("t3_found", 80);
    chk("t3_core", found_core, 3'd0);
    chk("t3_msg", found_msg, mk(8'h65));
    enable = 1'b0;
    pulse_resume();
    chk("t3_resume", found, 1'b0);
    all_hit = 1'b0; lat[1] = 20;
    target = NOHIT;

    // 4: drain with two in flight
    enable = 1'b1;
    offer(mk(8'h66), 10, ok);
    chk("t4_valid_f", core_msg_valid, 2'b10);
    offer(mk(8'h67), 10, ok);
    chk("t4_valid_g", core_msg_valid, 2'b01);
    chk("t4_busy", busy, 2'b11);
    enable = 1'b0;
    cand_data = mk(8'h68); cand_valid = 1'b1;
    pulses = 0; rdy_seen = 1'b0;
    for (int t = 0; t < 60 && busy !== 2'b00; t++) begin
      @(negedge clk);
      if (core_msg_valid != 2'b00) pulses++;
      if (cand_ready) rdy_seen = 1'b1;
    end
    repeat (3) begin
      @(negedge clk);
      if (core_msg_valid != 2'b00) pulses++;
      if (cand_ready) rdy_seen = 1'b1;
    end
    chk("t4_busy_clear", busy, 2'b00);
    chk("t4_pulses", pulses, 0);
    chk("t4_ready", rdy_seen, 1'b0);
    chk("t4_found", found, 1'b0);
    cand_valid = 1'b0;

    // table: round-robin dispatch and hit capture
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      target = vecs[i].tgt;
      offer(vecs[i].cand, 10, ok);
      chk($sformatf("v%0d_acc", i), ok, 1'b1);
      chk($sformatf("v%0d_valid", i), core_msg_valid, vecs[i].exp_valid);
      chk($sformatf("v%0d_lane", i), lane(vecs[i].exp_core), vecs[i].cand);
      wait_idle($sformatf("v%0d_idle", i), 60);
      chk($sformatf("v%0d_found", i), found, vecs[i].exp_hit);
      if (vecs[i].exp_hit) begin
        chk($sformatf("v%0d_core", i), found_core, 3'(vecs[i].exp_core));
        chk($sformatf("v%0d_msg", i), found_msg, vecs[i].cand);
        pulse_resume();
        chk($sformatf("v%0d_resume", i), found, 1'b0);
      end
    end

    // 6: reset with both cores busy, then a stray completion
    target = MD5_A;
    offer(MSG_A, 10, ok);
    chk("t6_valid_a", core_msg_valid, 2'b01);
    offer(MSG_B, 10, ok);
    chk("t6_valid_b", core_msg_valid, 2'b10);
    chk("t6_busy", busy, 2'b11);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_state("t6");
    reset = 1'b0;
    @(negedge clk);
    inj_out = MD5_A; inj_valid = 2'b11;
    @(negedge clk);
    inj_valid = 2'b00;
    repeat (3) @(negedge clk);
    chk("t6_late_found", found, 1'b0);
    chk("t6_late_busy", busy, 2'b00);
    offer(MSG_A, 10, ok);
    chk("t6_restart_valid", core_msg_valid, 2'b01);
    wait_found("t6_restart_found", 80);
    chk("t6_restart_core", found_core, 3'd0);
    chk("t6_restart_msg", found_msg, MSG_A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
